// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity, stop, device ACK check.
// Latency: accept -> clock inhibit for INHIBIT_CYCLES, start bit, then 11 device clocks; done/error pulse at the end.
// Backpressure: tx_ready is high only in IDLE; tx_valid at any other time is ignored. Optional watchdog: PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, RELEASE} state_t;

  state_t           state;
  logic             clk_meta, clk_sync, clk_prev;
  logic             data_meta, data_sync;
  logic             fall;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_q;
  logic             parity_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Busy is simply the complement of ready so the receive path sees it in lockstep.
  assign tx_busy = ~tx_ready;

  // Falling edge of the device clock, taken from the synchronized copy.
  assign fall = clk_prev & ~clk_sync;

  // Two-flop synchronizers for the asynchronous pads; idle-high line value on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Transmit FSM with registered pad enables and result pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      inh_cnt     <= '0;
      bit_cnt     <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          // tx_ready is still low during the done/error pulse cycle and rises one cycle later.
          tx_ready    <= 1'b1;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            data_q     <= tx_data;
            parity_q   <= ~^tx_data;
            inh_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            bit_cnt     <= '0;
            state       <= START;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
          end
        end
        START: begin
          // Release the clock with the start bit still driven; the device now clocks us.
          ps2_clk_oe <= 1'b0;
          state      <= SEND;
        end
        SEND: begin
          if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              ps2_data_oe <= ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~parity_q;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (fall) begin
            if (data_sync) begin
              tx_error <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (clk_sync && data_sync) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog on device clock activity; expiry overrides whatever the FSM chose this cycle.
      if ((state == SEND || state == ACK || state == RELEASE) && !fall) begin
        wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt == WD_LAST) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_done     <= 1'b0;
          tx_error    <= 1'b1;
          state       <= IDLE;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
// Latency: each transfer takes INH + ~180 cycles with the short device clock used here.
// Backpressure: exercises tx_valid held high across a busy transfer.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 200;
  localparam int HALF = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_done, tx_error;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  logic       rx_bits [1:10];
  logic [7:0] rx_byte;

  logic       res_seen, res_done, res_err, res_both;
  logic       res_rdy_pulse, res_rdy_after, res_after_pulse;
  logic [1:0] res_oe_pulse;

  always #5 clock = ~clock;

  // Open-drain wired-AND of host and device on each line.
  assign ps2_clk_in  = ~(dev_clk_low | ps2_clk_oe);
  assign ps2_data_in = ~(dev_data_low | ps2_data_oe);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_simple(input logic [7:0] b);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    check("busy_after_accept", tx_busy, 1);
  endtask

  // Device side: wait for clock released with the start bit on data.
  task automatic wait_rts();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < INH + 40; i++) begin
      @(negedge clock);
      if (ps2_clk_in && !ps2_data_in && tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("rts_seen", ok, 1);
    repeat (2) @(negedge clock);
  endtask

  // Device generates n clock pulses and samples data on each rising edge.
  task automatic dev_bits(input int n);
    for (int k = 1; k <= n; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
      rx_bits[k]  = ps2_data_in;
      repeat (HALF) @(negedge clock);
    end
  endtask

  // Eleventh clock with the device pulling data low, then both lines released.
  task automatic dev_ack();
    dev_data_low = 1'b1;
    repeat (2) @(negedge clock);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clock);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic par);
    for (int i = 0; i < 8; i++) rx_byte[i] = rx_bits[i+1];
    check({tag, "_byte"}, rx_byte, b);
    check({tag, "_parity"}, rx_bits[9], par);
    check({tag, "_stop"}, rx_bits[10], 1);
  endtask

  // Watch for the first done/error pulse and the cycle after it.
  task automatic wait_result();
    res_seen = 0; res_done = 0; res_err = 0; res_both = 0;
    res_rdy_pulse = 0; res_rdy_after = 0; res_after_pulse = 0; res_oe_pulse = 2'b11;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (tx_done && tx_error) res_both = 1;
      if (tx_done || tx_error) begin
        res_seen        = 1;
        res_done        = tx_done;
        res_err         = tx_error;
        res_rdy_pulse   = tx_ready;
        res_oe_pulse    = {ps2_clk_oe, ps2_data_oe};
        @(negedge clock);
        res_rdy_after   = tx_ready;
        res_after_pulse = tx_done | tx_error;
        break;
      end
    end
    check("result_seen", res_seen, 1);
    check("done_err_exclusive", res_both, 0);
    check("ready_low_in_pulse", res_rdy_pulse, 0);
    check("ready_after_pulse", res_rdy_after, 1);
    check("pulse_one_cycle", res_after_pulse, 0);
  endtask

  initial begin
    int clk_hi_cnt, data_rise_idx, err_idx, err_cycles;
    logic [1:0] oe_at_err;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_pulses", {tx_done, tx_error}, 0);
    reset = 1'b0;
    @(negedge clock);

    // 0xED with inhibit/start timing: clock low INH+1 cycles, data rises at START.
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    clk_hi_cnt    = 0;
    data_rise_idx = 0;
    for (int i = 1; i <= INH + 2; i++) begin
      @(negedge clock);
      if (i == 1) begin
        tx_valid = 1'b0;
        check("ed_ready_low", tx_ready, 0);
      end
      if (ps2_clk_oe) clk_hi_cnt++;
      if (ps2_data_oe && data_rise_idx == 0) data_rise_idx = i;
    end
    check("inhibit_len", clk_hi_cnt, INH + 1);
    check("start_bit_idx", data_rise_idx, INH + 1);
    check("clk_released", ps2_clk_oe, 0);
    wait_rts();
    dev_bits(10);
    dev_ack();
    wait_result();
    check("ed_done", res_done, 1);
    check("ed_no_err", res_err, 0);
    check_frame("ed", 8'hED, 1'b1);

    // 0xFF then 0x01 with tx_valid held high throughout.
    @(negedge clock);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clock);
    check("ff_ready_low", tx_ready, 0);
    tx_data = 8'h01;
    wait_rts();
    dev_bits(10);
    dev_ack();
    wait_result();
    check("ff_done", res_done, 1);
    check_frame("ff", 8'hFF, 1'b1);
    @(negedge clock);
    check("second_accepted", {tx_ready, ps2_clk_oe}, 2'b01);
    tx_valid = 1'b0;
    wait_rts();
    dev_bits(10);
    dev_ack();
    wait_result();
    check("01_done", res_done, 1);
    check_frame("01", 8'h01, 1'b0);

    // NACK: device leaves data high on the eleventh clock.
    send_simple(8'h55);
    wait_rts();
    dev_bits(10);
    repeat (2) @(negedge clock);
    dev_clk_low = 1'b1;
    wait_result();
    dev_clk_low = 1'b0;
    check("nack_err", res_err, 1);
    check("nack_no_done", res_done, 0);
    check("nack_oe", res_oe_pulse, 2'b00);
    check_frame("55", 8'h55, 1'b1);
    repeat (HALF) @(negedge clock);

    // Reset after the fifth fall, then a clean 0x00 transfer.
    send_simple(8'h3C);
    wait_rts();
    dev_bits(5);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("midrst_ready", tx_ready, 1);
    check("midrst_pulses", {tx_done, tx_error}, 0);
    reset = 1'b0;
    send_simple(8'h00);
    wait_rts();
    dev_bits(10);
    dev_ack();
    wait_result();
    check("00_done", res_done, 1);
    check_frame("00", 8'h00, 1'b1);

    // Device stops clocking after the third fall.
    send_simple(8'hA5);
    wait_rts();
    dev_bits(2);
    dev_clk_low = 1'b1;
    err_idx    = 0;
    err_cycles = 0;
    oe_at_err  = 2'b11;
    for (int j = 1; j <= TMO + 40; j++) begin
      @(negedge clock);
      if (j == HALF) dev_clk_low = 1'b0;
      if (tx_error) begin
        err_cycles++;
        if (err_idx == 0) begin
          err_idx   = j;
          oe_at_err = {ps2_clk_oe, ps2_data_oe};
        end
      end
    end
`ifdef PS2_TX_TIMEOUT_EN
    check("timeout_idx", err_idx, TMO + 3);
    check("timeout_pulse_len", err_cycles, 1);
    check("timeout_oe", oe_at_err, 2'b00);
    check("timeout_ready", tx_ready, 1);
`else
    check("stall_no_err", err_cycles, 0);
    check("stall_busy", tx_busy, 1);
    check("stall_ready", tx_ready, 0);
`endif
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("final_ready", tx_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
